// File: rtl/cal_pkg.sv
// Shared opcode encodings, flag bit positions and multiply-sequencer state
// type for the calculation datapath.
package cal_pkg;

   localparam int unsigned OP_WIDTH = 4;

   localparam logic [OP_WIDTH-1:0] OP_PASSA = 4'd0;
   localparam logic [OP_WIDTH-1:0] OP_ADD   = 4'd1;
   localparam logic [OP_WIDTH-1:0] OP_SUB   = 4'd2;
   localparam logic [OP_WIDTH-1:0] OP_AND   = 4'd3;
   localparam logic [OP_WIDTH-1:0] OP_OR    = 4'd4;
   localparam logic [OP_WIDTH-1:0] OP_XOR   = 4'd5;
   localparam logic [OP_WIDTH-1:0] OP_NOT   = 4'd6;
   localparam logic [OP_WIDTH-1:0] OP_SHL   = 4'd7;
   localparam logic [OP_WIDTH-1:0] OP_SHR   = 4'd8;
   localparam logic [OP_WIDTH-1:0] OP_ADDI  = 4'd9;
   localparam logic [OP_WIDTH-1:0] OP_SUBI  = 4'd10;
   localparam logic [OP_WIDTH-1:0] OP_MUL   = 4'd11;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mul_state_e;

endpackage

// File: rtl/cal_regfile.sv
// Register file: one synchronous write port, two enable-gated combinational
// read ports; a disabled read port returns zero.
module cal_regfile
   import cal_pkg::*;
#(
   parameter int unsigned REGISTER_LEN = 10,
   parameter int unsigned NUM_REGS     = 4,
   localparam int unsigned AW          = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [AW-1:0]           wa,
   input  logic [REGISTER_LEN-1:0] wd,
   input  logic                    rae,
   input  logic [AW-1:0]           raa,
   input  logic                    rbe,
   input  logic [AW-1:0]           rba,
   output logic [REGISTER_LEN-1:0] rda,
   output logic [REGISTER_LEN-1:0] rdb
);

   logic [REGISTER_LEN-1:0] regs_q [NUM_REGS];
   logic [REGISTER_LEN-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wa] = wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rda = rae ? regs_q[raa] : '0;
   assign rdb = rbe ? regs_q[rba] : '0;

endmodule

// File: rtl/cal_datapath.sv
// Calculation datapath: register file, ALU with NZCV flags, registered
// output port and an iterative shift-add multiplier with Busy/Done handshake.
module cal_datapath
   import cal_pkg::*;
#(
   parameter int unsigned REGISTER_LEN = 10,
   parameter int unsigned NUM_REGS     = 4,
   parameter int unsigned IMM_LEN      = 4,
   localparam int unsigned AW          = $clog2(NUM_REGS)
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic [REGISTER_LEN-1:0] DataIn,
   input  logic                    IE,
   input  logic                    WE,
   input  logic [AW-1:0]           WA,
   input  logic                    RAE,
   input  logic                    RBE,
   input  logic [AW-1:0]           RAA,
   input  logic [AW-1:0]           RBA,
   input  logic [OP_WIDTH-1:0]     OP,
   input  logic [IMM_LEN-1:0]      Cal_value,
   input  logic                    ZE,
   input  logic                    OE,
   input  logic                    Start,
   output logic [REGISTER_LEN-1:0] DataOut,
   output logic [3:0]              Flags,
   output logic                    Q,
   output logic                    Busy,
   output logic                    Done
);

   localparam int unsigned L  = REGISTER_LEN;
   localparam int unsigned CW = $clog2(REGISTER_LEN);

   logic [L-1:0]   rd_a, rd_b, imm_ext;
   logic [L:0]     alu_r;
   logic           alu_v;

   mul_state_e     st_q, st_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [L-1:0]   mcand_q, mcand_d;
   logic [2*L-1:0] acc_q, acc_d;
   logic [AW-1:0]  wa_cap_q, wa_cap_d;
   logic           we_cap_q, we_cap_d;
   logic           ze_cap_q, ze_cap_d;
   logic           done_q, done_d;
   logic [L-1:0]   dout_q, dout_d;
   logic [3:0]     flags_q, flags_d;

   logic [L:0]     mul_sum;
   logic [2*L-1:0] mul_next;

   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic [L-1:0]   wr_data;

   cal_regfile #(
      .REGISTER_LEN(REGISTER_LEN),
      .NUM_REGS    (NUM_REGS)
   ) u_regfile (
      .clk  (Clock),
      .rst_n(Reset_n),
      .we   (wr_en),
      .wa   (wr_addr),
      .wd   (wr_data),
      .rae  (RAE),
      .raa  (RAA),
      .rbe  (RBE),
      .rba  (RBA),
      .rda  (rd_a),
      .rdb  (rd_b)
   );

   assign imm_ext = L'(Cal_value);

   // Bit L of alu_r is the carry/borrow/shifted-out bit, zero for logic ops.
   always_comb begin
      alu_r = {1'b0, rd_a};
      alu_v = 1'b0;
      case (OP)
         OP_ADD: begin
            alu_r = {1'b0, rd_a} + {1'b0, rd_b};
            alu_v = (rd_a[L-1] == rd_b[L-1]) && (alu_r[L-1] != rd_a[L-1]);
         end
         OP_SUB: begin
            alu_r = {1'b0, rd_a} - {1'b0, rd_b};
            alu_v = (rd_a[L-1] != rd_b[L-1]) && (alu_r[L-1] != rd_a[L-1]);
         end
         OP_AND:  alu_r = {1'b0, rd_a & rd_b};
         OP_OR:   alu_r = {1'b0, rd_a | rd_b};
         OP_XOR:  alu_r = {1'b0, rd_a ^ rd_b};
         OP_NOT:  alu_r = {1'b0, ~rd_a};
         OP_SHL:  alu_r = {rd_a, 1'b0};
         OP_SHR:  alu_r = {rd_a[0], 1'b0, rd_a[L-1:1]};
         OP_ADDI: begin
            alu_r = {1'b0, rd_a} + {1'b0, imm_ext};
            alu_v = (rd_a[L-1] == imm_ext[L-1]) && (alu_r[L-1] != rd_a[L-1]);
         end
         OP_SUBI: begin
            alu_r = {1'b0, rd_a} - {1'b0, imm_ext};
            alu_v = (rd_a[L-1] != imm_ext[L-1]) && (alu_r[L-1] != rd_a[L-1]);
         end
         OP_MUL:  alu_r = '0;
         default: alu_r = {1'b0, rd_a};
      endcase
   end

   // Right-shifting accumulator: upper half collects partial sums, lower half
   // starts as the multiplier and is consumed one bit per step.
   assign mul_sum  = {1'b0, acc_q[2*L-1:L]} + (acc_q[0] ? {1'b0, mcand_q} : {(L+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[L-1:1]};

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      wa_cap_d = wa_cap_q;
      we_cap_d = we_cap_q;
      ze_cap_d = ze_cap_q;
      done_d   = 1'b0;
      dout_d   = OE ? alu_r[L-1:0] : dout_q;
      flags_d  = flags_q;
      wr_en    = 1'b0;
      wr_addr  = WA;
      wr_data  = IE ? DataIn : alu_r[L-1:0];

      case (st_q)
         ST_IDLE: begin
            if (OP == OP_MUL) begin
               if (Start) begin
                  st_d     = ST_RUN;
                  cnt_d    = '0;
                  mcand_d  = rd_a;
                  acc_d    = {{L{1'b0}}, rd_b};
                  wa_cap_d = WA;
                  we_cap_d = WE;
                  ze_cap_d = ZE;
               end
            end else begin
               wr_en = WE;
               if (ZE) begin
                  flags_d[FLAG_N] = alu_r[L-1];
                  flags_d[FLAG_Z] = (alu_r[L-1:0] == '0);
                  flags_d[FLAG_C] = alu_r[L];
                  flags_d[FLAG_V] = alu_v;
               end
            end
         end
         ST_RUN: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(L-1)) begin
               st_d    = ST_IDLE;
               done_d  = 1'b1;
               wr_en   = we_cap_q;
               wr_addr = wa_cap_q;
               wr_data = mul_next[L-1:0];
               if (ze_cap_q) begin
                  flags_d[FLAG_N] = mul_next[L-1];
                  flags_d[FLAG_Z] = (mul_next[L-1:0] == '0);
                  flags_d[FLAG_C] = (mul_next[2*L-1:L] != '0);
                  flags_d[FLAG_V] = 1'b0;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         st_q     <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         wa_cap_q <= '0;
         we_cap_q <= 1'b0;
         ze_cap_q <= 1'b0;
         done_q   <= 1'b0;
         dout_q   <= '0;
         flags_q  <= '0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         wa_cap_q <= wa_cap_d;
         we_cap_q <= we_cap_d;
         ze_cap_q <= ze_cap_d;
         done_q   <= done_d;
         dout_q   <= dout_d;
         flags_q  <= flags_d;
      end
   end

   assign DataOut = dout_q;
   assign Flags   = flags_q;
   assign Q       = flags_q[FLAG_Z];
   assign Busy    = (st_q == ST_RUN);
   assign Done    = done_q;

endmodule
